ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Round-robin bus arbiter that shares one AHB requester port among `NUM_REQ` upstream managers. It sits between the managers' request/lock lines and the shared address/control mux. It produces a one-hot grant, the address-phase owner index (`hmaster`), the data-phase owner index, and `hmastlock`. Ownership is held across fixed-length bursts, open INCR bursts and locked sequences. Handover happens only on AHB-legal arbitration points.

## Interface
- `NUM_REQ`, 4: number of managers, 2..16.
- `HMASTER_WIDTH`, 4: width of owner indices; must satisfy 2**HMASTER_WIDTH >= NUM_REQ.
- `DEFAULT_REQ`, 0: park owner when nobody requests.
- `hclk` in 1: clock; one clock domain only, all logic on rising edge.
- `hrst` in 1: synchronous, active-high reset.
- `hbusreq` in NUM_REQ: per-manager bus request.
- `hlock` in NUM_REQ: per-manager lock request; only meaningful while that manager also has `hbusreq`.
- `htrans` in 2: muxed bus transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- `hburst` in 3: muxed burst type (0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16).
- `hready` in 1: completer `hreadyout`; transfer accepted when high.
- `hgrant` out NUM_REQ: one-hot grant, registered.
- `hmaster` out HMASTER_WIDTH: address-phase owner index, registered.
- `hmaster_data` out HMASTER_WIDTH: data-phase owner index, registered; steers `hwdata` and return muxes.
- `hmastlock` out 1: current ownership is locked, registered.

## Operation
- FSM states:
  - PARK: no burst in flight.
  - BURST: fixed-length burst in flight; beat counter `cnt` 5 bits.
  - INCR: open-length INCR burst in flight.
  - LOCKED: overlay flag `lk`, orthogonal to the states above.
- All state updates are qualified by `hready=1`. With `hready=0`, every register holds.
- On an accepted NONSEQ:
  - SINGLE: go to PARK-equivalent; this is an arbitration point next edge.
  - INCR: go to INCR.
  - WRAPn/INCRn: go to BURST with `cnt=n-1`.
- Accepted SEQ in BURST decrements `cnt`. BUSY neither decrements nor releases.
- Arbitration point (AP) is an edge with `hready=1` and any of:
  - state PARK;
  - BURST with `cnt==0` after the final beat;
  - BURST with `htrans==IDLE` (early termination);
  - INCR with owner `hbusreq=0`, or INCR with `htrans==IDLE`.
- AP is suppressed while `lk=1` and the owner's `hlock=1`.
- Winner at an AP:
  - Search `hbusreq` starting at `(owner+1) mod NUM_REQ`; wrap at NUM_REQ-1→0. First set bit wins.
  - Current owner is checked last, so a continuous requester cannot starve others.
  - If no request is set, grant `DEFAULT_REQ`.
  - If the winner has `hlock=1`, set `lk=1` and `hmastlock=1`. Otherwise clear both.
- `hmaster_data <= hmaster` on every edge with `hready=1`. Data phase always trails address phase by exactly one accepted transfer.
- Requests from indices >= NUM_REQ do not exist. The `hmaster` upper bits are zero-extended.

## Timing
- Reset values:
  - `hgrant` = one-hot(`DEFAULT_REQ`);
  - `hmaster` = `hmaster_data` = `DEFAULT_REQ`;
  - `hmastlock=0`; state PARK; `cnt=0`; `lk=0`; RR pointer = `DEFAULT_REQ`.
- Grant latency: a request seen at an AP edge produces `hgrant`/`hmaster` on that edge's registered outputs, i.e. visible the following cycle. Best case is one cycle from `hbusreq` rise to grant while parked.
- `hgrant`, `hmaster` and `hmastlock` change only on AP edges, always together.
- Stall: `hready=0` on the last beat delays the AP until the edge where `hready=1`.
- Simultaneous events:
  - AP and new requests on the same edge: new requests participate.
  - Owner drops `hbusreq` mid fixed burst: the burst still completes; there is no AP before `cnt==0` unless IDLE.
- Reset mid-burst: all registers return to reset values on the next edge regardless of `hready`. The burst is abandoned.
- `hgrant` is always exactly one-hot. This is asserted in the bench.

## Test plan
- Reset with `hbusreq=0`: `hgrant=4'b0001`, `hmaster=0`, `hmaster_data=0`, `hmastlock=0`; hold 10 cycles → no change.
- Managers 0..3 all request SINGLE NONSEQ continuously, `hready=1` → `hmaster` sequence 1,2,3,0,1… with one change per cycle; `hmaster_data` lags by one cycle.
- Manager 2 owns, issues INCR4 (NONSEQ + 3 SEQ) while manager 3 requests → `hmaster` stays 2 for 4 accepted beats, then becomes 3.
- Same INCR4 with `hready=0` for 3 cycles on beat 4 → grant to 3 is delayed exactly 3 cycles; `hmaster_data` is frozen during the stall.
- Manager 1 requests with `hlock=1`, issues two SINGLEs while 0 and 2 request → `hmastlock=1`; `hmaster=1` is held until `hlock` drops; the next grant goes to 2.
- Assert `hrst` at beat 2 of an INCR8 owned by 3 → next cycle `hgrant=0001`, `hmaster=0`, `hmastlock=0`; a fresh SINGLE from 3 is granted one cycle after reset release.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, address/data-phase owner indices
// and hmastlock; ownership is held across bursts and locked sequences.
module ahb_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int HMASTER_WIDTH = 4,
   parameter int DEFAULT_REQ   = 0
) (
   input  logic                     hclk,
   input  logic                     hrst,
   input  logic [NUM_REQ-1:0]       hbusreq,
   input  logic [NUM_REQ-1:0]       hlock,
   input  logic [1:0]               htrans,
   input  logic [2:0]               hburst,
   input  logic                     hready,
   output logic [NUM_REQ-1:0]       hgrant,
   output logic [HMASTER_WIDTH-1:0] hmaster,
   output logic [HMASTER_WIDTH-1:0] hmaster_data,
   output logic                     hmastlock,
   output logic [1:0]               fsm_state
);

   localparam logic [1:0] ST_PARK  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_INCR  = 2'd2;

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam int NSLOT = 1 << HMASTER_WIDTH;

   logic [1:0]               st, st_n;
   logic [4:0]               cnt, cnt_n;
   logic                     lk;
   logic                     ap, take;
   logic [HMASTER_WIDTH-1:0] win, idx;
   logic                     found;
   logic [NSLOT-1:0]         req_ext, lock_ext;

   // Widened to the full index space so non-existent managers read as zero.
   assign req_ext   = NSLOT'(hbusreq);
   assign lock_ext  = NSLOT'(hlock & hbusreq);
   assign hmastlock = lk;
   assign fsm_state = st;

   // Handshake: a transfer is accepted on an edge with hready=1; on any edge
   // with hready=0 nothing advances and every register holds.
   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      ap    = 1'b0;
      if (htrans == TR_NONSEQ) begin
         case (hburst)
            3'd0: begin
               st_n  = ST_PARK;
               cnt_n = 5'd0;
               ap    = 1'b1;
            end
            3'd1: begin
               st_n  = ST_INCR;
               cnt_n = 5'd0;
            end
            3'd2, 3'd3: begin
               st_n  = ST_BURST;
               cnt_n = 5'd3;
            end
            3'd4, 3'd5: begin
               st_n  = ST_BURST;
               cnt_n = 5'd7;
            end
            default: begin
               st_n  = ST_BURST;
               cnt_n = 5'd15;
            end
         endcase
      end else begin
         case (st)
            ST_PARK: ap = 1'b1;
            ST_BURST: begin
               if (htrans == TR_IDLE || cnt == 5'd0) begin
                  st_n  = ST_PARK;
                  cnt_n = 5'd0;
                  ap    = 1'b1;
               end else if (htrans == TR_SEQ) begin
                  cnt_n = cnt - 5'd1;
                  if (cnt == 5'd1) begin
                     st_n = ST_PARK;
                     ap   = 1'b1;
                  end
               end
            end
            ST_INCR: begin
               if (htrans == TR_IDLE || !req_ext[hmaster]) begin
                  st_n = ST_PARK;
                  ap   = 1'b1;
               end
            end
            default: begin
               st_n  = ST_PARK;
               cnt_n = 5'd0;
               ap    = 1'b1;
            end
         endcase
      end
   end

   // Search starts just past the owner; the owner itself is examined last.
   always_comb begin
      win   = HMASTER_WIDTH'(DEFAULT_REQ);
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = HMASTER_WIDTH'(((int'(hmaster) + i) >= NUM_REQ) ?
                             (int'(hmaster) + i - NUM_REQ) : (int'(hmaster) + i));
         if (!found && req_ext[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign take = ap && !(lk && lock_ext[hmaster]);

   always_ff @(posedge hclk) begin
      if (hrst) begin
         st           <= ST_PARK;
         cnt          <= 5'd0;
         lk           <= 1'b0;
         hmaster      <= HMASTER_WIDTH'(DEFAULT_REQ);
         hmaster_data <= HMASTER_WIDTH'(DEFAULT_REQ);
         hgrant       <= NUM_REQ'(1) << DEFAULT_REQ;
      end else if (hready) begin
         st           <= st_n;
         cnt          <= cnt_n;
         hmaster_data <= hmaster;
         if (take) begin
            hmaster <= win;
            hgrant  <= NUM_REQ'(1) << win;
            lk      <= lock_ext[win];
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round-robin, bursts, stalls, lock,
// reset mid-burst and open INCR release, with hand-computed expectations.
module tb_ahb_arbiter;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] NONSEQ = 2'd2;
   localparam logic [1:0] SEQ    = 2'd3;

   logic       hclk = 1'b0;
   logic       hrst;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;
   logic [3:0] hgrant;
   logic [3:0] hmaster;
   logic [3:0] hmaster_data;
   logic       hmastlock;
   logic [1:0] fsm_state;

   int checks = 0;
   int errors = 0;
   bit mon_on = 1'b0;
   logic [3:0] exp_q[$];

   ahb_arbiter #(.NUM_REQ(4), .HMASTER_WIDTH(4), .DEFAULT_REQ(0)) dut (
      .hclk(hclk), .hrst(hrst), .hbusreq(hbusreq), .hlock(hlock),
      .htrans(htrans), .hburst(hburst), .hready(hready), .hgrant(hgrant),
      .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock),
      .fsm_state(fsm_state)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
      hbusreq = req;
      hlock   = lck;
      htrans  = tr;
      hburst  = bu;
      hready  = rdy;
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   // Grant must stay one-hot and agree with the address-phase owner.
   always @(negedge hclk) begin
      if (mon_on) begin
         check("onehot", 32'($onehot(hgrant)), 32'd1);
         check("grant_vs_hmaster", 32'(hgrant), 32'd1 << hmaster);
      end
   end

   initial begin
      logic [3:0] e;
      logic [3:0] prev;

      // Reset and idle park
      hrst = 1'b1;
      drive(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);
      step();
      step();
      mon_on = 1'b1;
      check("rst_hgrant", 32'(hgrant), 32'h1);
      check("rst_hmaster", 32'(hmaster), 32'h0);
      check("rst_hmaster_data", 32'(hmaster_data), 32'h0);
      check("rst_hmastlock", 32'(hmastlock), 32'h0);
      check("rst_state", 32'(fsm_state), 32'h0);
      hrst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_hgrant", 32'(hgrant), 32'h1);
         check("idle_hmaster", 32'(hmaster), 32'h0);
      end

      // Everyone requests SINGLEs: owner rotates every cycle
      e = 4'd0;
      for (int i = 0; i < 8; i++) begin
         e = (e == 4'd3) ? 4'd0 : e + 4'd1;
         exp_q.push_back(e);
      end
      drive(4'b1111, 4'b0000, NONSEQ, 3'd0, 1'b1);
      prev = 4'd0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         step();
         check("rr_hmaster", 32'(hmaster), 32'(e));
         check("rr_hmaster_data", 32'(hmaster_data), 32'(prev));
         prev = e;
      end

      // Manager 2 takes the bus, then INCR4 while manager 3 waits
      drive(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1);
      step();
      check("own2_hmaster", 32'(hmaster), 32'h2);
      drive(4'b1100, 4'b0000, NONSEQ, 3'd3, 1'b1);
      step();
      check("incr4_b1_hmaster", 32'(hmaster), 32'h2);
      check("incr4_b1_state", 32'(fsm_state), 32'h1);
      htrans = SEQ;
      step();
      check("incr4_b2_hmaster", 32'(hmaster), 32'h2);
      step();
      check("incr4_b3_hmaster", 32'(hmaster), 32'h2);
      step();
      check("incr4_end_hmaster", 32'(hmaster), 32'h3);
      check("incr4_end_hgrant", 32'(hgrant), 32'h8);
      check("incr4_end_hmaster_data", 32'(hmaster_data), 32'h2);

      // Back to manager 2 (search from 3 wraps 0,1,2), then stalled INCR4
      drive(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1);
      step();
      check("own2b_hmaster", 32'(hmaster), 32'h2);
      check("own2b_hmaster_data", 32'(hmaster_data), 32'h3);
      drive(4'b1100, 4'b0000, NONSEQ, 3'd2, 1'b1);
      step();
      htrans = SEQ;
      step();
      step();
      check("stall_pre_hmaster_data", 32'(hmaster_data), 32'h2);
      hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hmaster", 32'(hmaster), 32'h2);
         check("stall_hmaster_data", 32'(hmaster_data), 32'h2);
         check("stall_state", 32'(fsm_state), 32'h1);
      end
      hready = 1'b1;
      step();
      check("stall_end_hmaster", 32'(hmaster), 32'h3);
      check("stall_end_hmaster_data", 32'(hmaster_data), 32'h2);
      htrans = IDLE;
      hbusreq = 4'b1000;
      step();
      check("stall_after_hmaster_data", 32'(hmaster_data), 32'h3);

      // Locked sequence by manager 1 while 0 and 2 also request
      drive(4'b0001, 4'b0000, IDLE, 3'd0, 1'b1);
      step();
      check("own0_hmaster", 32'(hmaster), 32'h0);
      drive(4'b0111, 4'b0010, IDLE, 3'd0, 1'b1);
      step();
      check("lock_hmaster", 32'(hmaster), 32'h1);
      check("lock_hmastlock", 32'(hmastlock), 32'h1);
      drive(4'b0111, 4'b0010, NONSEQ, 3'd0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         check("lock_single_hmaster", 32'(hmaster), 32'h1);
         check("lock_single_hmastlock", 32'(hmastlock), 32'h1);
      end
      htrans = IDLE;
      step();
      check("lock_idle_hmaster", 32'(hmaster), 32'h1);
      hlock = 4'b0000;
      step();
      check("unlock_hmaster", 32'(hmaster), 32'h2);
      check("unlock_hmastlock", 32'(hmastlock), 32'h0);

      // Reset in the middle of a locked INCR8 owned by manager 3
      drive(4'b1000, 4'b1000, IDLE, 3'd0, 1'b1);
      step();
      check("own3_hmaster", 32'(hmaster), 32'h3);
      check("own3_hmastlock", 32'(hmastlock), 32'h1);
      drive(4'b1000, 4'b1000, NONSEQ, 3'd5, 1'b1);
      step();
      htrans = SEQ;
      step();
      check("incr8_b2_state", 32'(fsm_state), 32'h1);
      hrst = 1'b1;
      hready = 1'b0;
      step();
      check("midrst_hgrant", 32'(hgrant), 32'h1);
      check("midrst_hmaster", 32'(hmaster), 32'h0);
      check("midrst_hmaster_data", 32'(hmaster_data), 32'h0);
      check("midrst_hmastlock", 32'(hmastlock), 32'h0);
      hrst = 1'b0;
      drive(4'b1000, 4'b0000, NONSEQ, 3'd0, 1'b1);
      step();
      check("postrst_hmaster", 32'(hmaster), 32'h3);
      check("postrst_hmastlock", 32'(hmastlock), 32'h0);

      // Open INCR held while owner requests, released when it drops hbusreq
      drive(4'b1001, 4'b0000, NONSEQ, 3'd1, 1'b1);
      step();
      check("incr_start_hmaster", 32'(hmaster), 32'h3);
      check("incr_start_state", 32'(fsm_state), 32'h2);
      htrans = SEQ;
      step();
      check("incr_hold_hmaster", 32'(hmaster), 32'h3);
      hbusreq = 4'b0001;
      step();
      check("incr_release_hmaster", 32'(hmaster), 32'h0);
      check("incr_release_state", 32'(fsm_state), 32'h0);

      // Early IDLE termination of a fixed burst
      drive(4'b0011, 4'b0000, NONSEQ, 3'd3, 1'b1);
      step();
      check("early_b1_hmaster", 32'(hmaster), 32'h0);
      htrans = IDLE;
      step();
      check("early_idle_hmaster", 32'(hmaster), 32'h1);

      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
